// File: rtl/me_ctrl.sv
// Motion-estimation search controller: sequences current-MB and search-window reads and keeps the best SAD.
// Optional feature: define ME_CTRL_ZERO_SAD_EXIT_EN to finish early on the first zero SAD.
module me_ctrl #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48,
    parameter int NPOS       = SEARCH_DIM - MACRO_DIM + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic                          pe_ready_i,
    output logic                          cur_rd_en_o,
    output logic [$clog2(MACRO_DIM)-1:0]  cur_col_o,
    output logic                          spr_rd_en_o,
    output logic [$clog2(NPOS)-1:0]       spr_row_o,
    output logic [$clog2(SEARCH_DIM)-1:0] spr_col_o,
    input  logic                          sad_valid_i,
    input  logic [15:0]                   sad_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [15:0]                   min_sad_o,
    output logic [5:0]                    mv_x_o,
    output logic [5:0]                    mv_y_o
);

    localparam int MW = $clog2(MACRO_DIM);
    localparam int NW = $clog2(NPOS);
    localparam int SW = $clog2(SEARCH_DIM);
    localparam logic [MW-1:0] CUR_LAST = MW'(MACRO_DIM - 1);
    localparam logic [NW-1:0] POS_LAST = NW'(NPOS - 1);
    localparam logic [SW-1:0] COL_LAST = SW'(SEARCH_DIM - 1);
    localparam logic [5:0]    MV_BIAS  = 6'((NPOS - 1) / 2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CURR,
        SEARCH,
        WAIT_SAD,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic [MW-1:0] curCol_q, curCol_d;
    logic [NW-1:0] sprRow_q, sprRow_d;
    logic [SW-1:0] sprCol_q, sprCol_d;
    logic [NW-1:0] cx_q, cx_d;
    logic [NW-1:0] cy_q, cy_d;
    logic [15:0]   minSad_q, minSad_d;
    logic [5:0]    mvX_q, mvX_d;
    logic [5:0]    mvY_q, mvY_d;

    logic sadAccept;
    logic lastSad;
    logic lastRead;
    logic zeroHit;

    assign sadAccept = sad_valid_i && ((state_q == SEARCH) || (state_q == WAIT_SAD));
    assign lastSad   = sadAccept && (cx_q == POS_LAST) && (cy_q == POS_LAST);
    assign lastRead  = (sprRow_q == POS_LAST) && (sprCol_q == COL_LAST);

`ifdef ME_CTRL_ZERO_SAD_EXIT_EN
    assign zeroHit = sadAccept && (sad_i == 16'd0);
`else
    assign zeroHit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The SAD stream decides completion; reads only move SEARCH on to WAIT_SAD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = LOAD_CURR;
            end
            LOAD_CURR: begin
                if (cur_rd_en_o && (curCol_q == CUR_LAST)) state_d = SEARCH;
            end
            SEARCH, WAIT_SAD: begin
                if (lastSad || zeroHit) begin
                    state_d = DONE;
                end else if (spr_rd_en_o && lastRead) begin
                    state_d = WAIT_SAD;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q == LOAD_CURR) || (state_q == SEARCH) || (state_q == WAIT_SAD);
        done_o      = (state_q == DONE);
        cur_rd_en_o = (state_q == LOAD_CURR) && pe_ready_i;
        spr_rd_en_o = (state_q == SEARCH) && pe_ready_i;
    end

    always_comb begin
        curCol_d = curCol_q;
        sprRow_d = sprRow_q;
        sprCol_d = sprCol_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        minSad_d = minSad_q;
        mvX_d    = mvX_q;
        mvY_d    = mvY_q;

        if ((state_q == IDLE) && start_i) begin
            curCol_d = '0;
            sprRow_d = '0;
            sprCol_d = '0;
            cx_d     = '0;
            cy_d     = '0;
            minSad_d = 16'hFFFF;
            mvX_d    = '0;
            mvY_d    = '0;
        end

        if (cur_rd_en_o) begin
            curCol_d = (curCol_q == CUR_LAST) ? '0 : curCol_q + 1'b1;
        end

        if (spr_rd_en_o) begin
            if (sprCol_q == COL_LAST) begin
                sprCol_d = '0;
                sprRow_d = lastRead ? '0 : sprRow_q + 1'b1;
            end else begin
                sprCol_d = sprCol_q + 1'b1;
            end
        end

        // Strict less-than keeps the earliest candidate on ties.
        if (sadAccept) begin
            if (cx_q == POS_LAST) begin
                cx_d = '0;
                cy_d = (cy_q == POS_LAST) ? '0 : cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
            if (sad_i < minSad_q) begin
                minSad_d = sad_i;
                mvX_d    = 6'(cx_q) - MV_BIAS;
                mvY_d    = 6'(cy_q) - MV_BIAS;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curCol_q <= '0;
            sprRow_q <= '0;
            sprCol_q <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            minSad_q <= 16'hFFFF;
            mvX_q    <= '0;
            mvY_q    <= '0;
        end else begin
            curCol_q <= curCol_d;
            sprRow_q <= sprRow_d;
            sprCol_q <= sprCol_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            minSad_q <= minSad_d;
            mvX_q    <= mvX_d;
            mvY_q    <= mvY_d;
        end
    end

    assign cur_col_o = curCol_q;
    assign spr_row_o = sprRow_q;
    assign spr_col_o = sprCol_q;
    assign min_sad_o = minSad_q;
    assign mv_x_o    = mvX_q;
    assign mv_y_o    = mvY_q;

endmodule

// File: tb/tb_me_ctrl.sv
// Scoreboard bench for me_ctrl: a datapath stand-in returns SADs once their columns are read,
// and a monitor checks read ordering and the final result against a raster-scan reference.
module tb_me_ctrl;

    localparam int MD    = 16;
    localparam int SD    = 48;
    localparam int NP    = SD - MD + 1;
    localparam int NCAND = NP * NP;
    localparam int NSPR  = NP * SD;
    localparam int MIN_LATENCY = 1 + MD + NSPR;

`ifdef ME_CTRL_ZERO_SAD_EXIT_EN
    localparam bit ZERO_EXIT = 1'b1;
`else
    localparam bit ZERO_EXIT = 1'b0;
`endif

    typedef struct {
        int minSad;
        int mvX;
        int mvY;
        bit zeroExit;
        bit checkLatency;
        int startEdge;
    } expect_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        peReady;
    logic        sadValid;
    logic [15:0] sad;
    logic        curRdEn;
    logic [3:0]  curCol;
    logic        sprRdEn;
    logic [5:0]  sprRow;
    logic [5:0]  sprCol;
    logic        busy;
    logic        done;
    logic [15:0] minSad;
    logic [5:0]  mvX;
    logic [5:0]  mvY;

    expect_t expQ[$];
    expect_t lastExp;
    int      sadMem[NCAND];
    int      cycle = 0;
    int      checks = 0;
    int      errors = 0;
    int      peMode = 0;
    bit      stray = 1'b0;
    int      curReads = 0;
    int      sprReads = 0;
    int      zeroCycle = -1;
    int      doneCount = 0;
    int      doneBefore = 0;

    me_ctrl #(.MACRO_DIM(MD), .SEARCH_DIM(SD)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .pe_ready_i  (peReady),
        .cur_rd_en_o (curRdEn),
        .cur_col_o   (curCol),
        .spr_rd_en_o (sprRdEn),
        .spr_row_o   (sprRow),
        .spr_col_o   (sprCol),
        .sad_valid_i (sadValid),
        .sad_i       (sad),
        .busy_o      (busy),
        .done_o      (done),
        .min_sad_o   (minSad),
        .mv_x_o      (mvX),
        .mv_y_o      (mvY)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Raster scan with strict less-than; stops at the first zero when early exit is built in.
    function automatic void refModel(output int m, output int mx, output int my, output bit zx);
        int best;
        best = -1;
        m    = 65535;
        zx   = 1'b0;
        for (int k = 0; k < NCAND; k++) begin
            if (sadMem[k] < m) begin
                m    = sadMem[k];
                best = k;
            end
            if (ZERO_EXIT && (sadMem[k] == 0)) begin
                zx = 1'b1;
                break;
            end
        end
        mx = (best < 0) ? 0 : (best % NP) - (NP - 1) / 2;
        my = (best < 0) ? 0 : (best / NP) - (NP - 1) / 2;
    endfunction

    // Datapath stand-in: candidate (cx,cy) is returned only after column cx+MD-1 of row cy was read.
    initial begin
        int sent;
        int cx;
        int cy;
        sent     = 0;
        peReady  = 1'b1;
        sadValid = 1'b0;
        sad      = '0;
        forever begin
            @(posedge clk);
            #1;
            case (peMode)
                0:       peReady = 1'b1;
                1:       peReady = ~peReady;
                default: peReady = 1'($urandom_range(0, 1));
            endcase
            sadValid = 1'b0;
            sad      = '0;
            if (!busy) sent = 0;
            if (stray) begin
                sadValid = 1'b1;
            end else if (busy && (sent < NCAND)) begin
                cy = sent / NP;
                cx = sent % NP;
                if ((sprReads >= cy * SD + cx + MD) && ($urandom_range(0, 3) != 0)) begin
                    sadValid = 1'b1;
                    sad      = 16'(sadMem[sent]);
                    sent++;
                end
            end
        end
    end

    // Monitor: read ordering on every strobe, scoreboard comparison on every done pulse.
    initial begin
        expect_t e;
        bit      doneLast;
        int      lat;
        doneLast = 1'b0;
        forever begin
            @(negedge clk);
            if (!peReady) checkOutput("strobe_gate", int'(curRdEn | sprRdEn), 0);
            if (done) begin
                checkOutput("done_width", int'(doneLast), 0);
                checkOutput("busy_at_done", int'(busy), 0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("min_sad", int'(minSad), e.minSad);
                    checkOutput("mv_x", int'($signed(mvX)), e.mvX);
                    checkOutput("mv_y", int'($signed(mvY)), e.mvY);
                    checkOutput("cur_read_count", curReads, MD);
                    if (!e.zeroExit) checkOutput("spr_read_count", sprReads, NSPR);
                    if (e.zeroExit) checkOutput("zero_exit_done_cycle", cycle, zeroCycle + 1);
                    if (e.checkLatency) begin
                        lat = cycle - e.startEdge;
                        checkOutput("latency_at_least_min", int'(lat >= MIN_LATENCY), 1);
                    end
                end
                doneCount++;
            end
            doneLast = done;
            if (!busy) begin
                curReads  = 0;
                sprReads  = 0;
                zeroCycle = -1;
            end else begin
                if (curRdEn) begin
                    checkOutput("cur_col", int'(curCol), curReads);
                    curReads++;
                end
                if (sprRdEn) begin
                    checkOutput("spr_row", int'(sprRow), sprReads / SD);
                    checkOutput("spr_col", int'(sprCol), sprReads % SD);
                    sprReads++;
                end
                if (sadValid && (sad == 16'd0) && (zeroCycle < 0)) zeroCycle = cycle;
            end
        end
    end

    task automatic applyStimulus(input int mode, input bit expectDone, input bit latency);
        expect_t e;
        refModel(e.minSad, e.mvX, e.mvY, e.zeroExit);
        e.checkLatency = latency;
        peMode         = mode;
        @(posedge clk);
        #1;
        doneBefore = doneCount;
        start      = 1'b1;
        e.startEdge = cycle + 1;
        if (expectDone) expQ.push_back(e);
        lastExp = e;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_after_start", int'(busy), 1);
        checkOutput("min_sad_cleared", int'(minSad), 65535);
        checkOutput("mv_x_cleared", int'($signed(mvX)), 0);
        checkOutput("mv_y_cleared", int'($signed(mvY)), 0);
    endtask

    task automatic waitDone();
        for (int i = 0; i < 20000; i++) begin
            if (doneCount > doneBefore) break;
            @(posedge clk);
        end
        if (doneCount <= doneBefore) checkOutput("done_timeout", 0, 1);
        #1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_cur_rd_en"}, int'(curRdEn), 0);
        checkOutput({tag, "_spr_rd_en"}, int'(sprRdEn), 0);
        checkOutput({tag, "_cur_col"}, int'(curCol), 0);
        checkOutput({tag, "_spr_row"}, int'(sprRow), 0);
        checkOutput({tag, "_spr_col"}, int'(sprCol), 0);
        checkOutput({tag, "_min_sad"}, int'(minSad), 65535);
        checkOutput({tag, "_mv_x"}, int'($signed(mvX)), 0);
        checkOutput({tag, "_mv_y"}, int'($signed(mvY)), 0);
    endtask

    initial begin
        int dc;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        rst = 1'b0;

        $display("[TB] nominal search");
        for (int k = 0; k < NCAND; k++) sadMem[k] = 500;
        sadMem[5 * NP + 20] = 37;
        applyStimulus(0, 1'b1, 1'b1);
        waitDone();
        checkOutput("nominal_min_sad", int'(minSad), 37);
        checkOutput("nominal_mv_x", int'($signed(mvX)), 4);
        checkOutput("nominal_mv_y", int'($signed(mvY)), -11);

        $display("[TB] tie search");
        for (int k = 0; k < NCAND; k++) sadMem[k] = 200;
        sadMem[3 * NP + 3]   = 100;
        sadMem[30 * NP + 30] = 100;
        applyStimulus(2, 1'b1, 1'b0);
        waitDone();
        checkOutput("tie_mv_x", int'($signed(mvX)), -13);
        checkOutput("tie_mv_y", int'($signed(mvY)), -13);

        $display("[TB] backpressure search with start while busy");
        for (int k = 0; k < NCAND; k++) sadMem[k] = int'($urandom_range(1000, 1200));
        applyStimulus(1, 1'b1, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (900) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone();

        $display("[TB] stray sad_valid while idle");
        dc    = doneCount;
        stray = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        stray = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold_min_sad", int'(minSad), lastExp.minSad);
        checkOutput("hold_mv_x", int'($signed(mvX)), lastExp.mvX);
        checkOutput("hold_mv_y", int'($signed(mvY)), lastExp.mvY);
        checkOutput("hold_busy", int'(busy), 0);
        checkOutput("hold_no_done", doneCount, dc);

        $display("[TB] zero SAD at candidate 10");
        for (int k = 0; k < NCAND; k++) sadMem[k] = int'($urandom_range(1, 65535));
        sadMem[10] = 0;
        applyStimulus(0, 1'b1, 1'b0);
        waitDone();
        checkOutput("zero_min_sad", int'(minSad), 0);
        checkOutput("zero_mv_x", int'($signed(mvX)), -6);
        checkOutput("zero_mv_y", int'($signed(mvY)), -16);

        $display("[TB] reset in the middle of a search");
        for (int k = 0; k < NCAND; k++) sadMem[k] = int'($urandom_range(1, 65535));
        applyStimulus(2, 1'b0, 1'b0);
        repeat (200) @(posedge clk);
        #2;
        dc  = doneCount;
        rst = 1'b1;
        #1;
        checkIdleOutputs("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("midreset_no_done", doneCount, dc);
        checkOutput("midreset_stays_idle", int'(busy), 0);

        $display("[TB] random search after reset");
        for (int k = 0; k < NCAND; k++) sadMem[k] = int'($urandom_range(0, 4000));
        applyStimulus(2, 1'b1, 1'b0);
        waitDone();
        checkOutput("scoreboard_drained", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
